// File: rtl/reg_file_mp_pkg.sv
// Shared widths and limits for the multi-port register file and its scoreboard.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef RF_MAX_RD
`define RF_MAX_RD 4
`endif
`ifndef RF_MAX_WR
`define RF_MAX_WR 2
`endif

package reg_file_mp_pkg;
  localparam int WORD_WIDTH     = `WORD_WIDTH;
  localparam int REG_ADDR_WIDTH = `REG_ADDR_WIDTH;
  localparam int RF_MAX_RD      = `RF_MAX_RD;
  localparam int RF_MAX_WR      = `RF_MAX_WR;
endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// Pending-write busy vector: alloc sets, writeback clears, set wins; x0 never busy.
module rf_scoreboard
  import reg_file_mp_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_WIDTH,
  parameter int NREGS  = 1 << ADDR_W,
  parameter int NRD    = 2,
  parameter int NWR    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_en,
  input  logic [ADDR_W-1:0]     alloc_addr,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] wa,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD-1:0]        busy_pre,
  output logic [NRD-1:0]        busy_post
);

  logic [NREGS-1:0] busy, busy_nxt;

  always_comb begin
    busy_nxt = busy;
    for (int r = 1; r < NREGS; r++) begin
      logic set, clr;
      set = alloc_en && (alloc_addr == ADDR_W'(r));
      clr = 1'b0;
      for (int j = 0; j < NWR; j++)
        if (we[j] && (wa[j*ADDR_W +: ADDR_W] == ADDR_W'(r))) clr = 1'b1;
      // A newly issued producer supersedes the one completing this cycle.
      if (set)      busy_nxt[r] = 1'b1;
      else if (clr) busy_nxt[r] = 1'b0;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  always_comb begin
    busy_pre  = '0;
    busy_post = '0;
    for (int i = 0; i < NRD; i++) begin
      busy_pre[i]  = busy[ra[i*ADDR_W +: ADDR_W]];
      busy_post[i] = busy_nxt[ra[i*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with registered reads, optional same-cycle forwarding
// and an integrated pending-write scoreboard.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int WORD_W = WORD_WIDTH,
  parameter int ADDR_W = REG_ADDR_WIDTH,
  parameter int NREGS  = 1 << ADDR_W,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter bit BYPASS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD*WORD_W-1:0] rd,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] wa,
  input  logic [NWR*WORD_W-1:0] wd,
  input  logic                  alloc_en,
  input  logic [ADDR_W-1:0]     alloc_addr
);

  if (NRD < 1 || NRD > RF_MAX_RD) begin : g_bad_nrd
    $error("reg_file_mp: NRD must be 1..%0d", RF_MAX_RD);
  end
  if (NWR < 1 || NWR > RF_MAX_WR) begin : g_bad_nwr
    $error("reg_file_mp: NWR must be 1..%0d", RF_MAX_WR);
  end

  logic [WORD_W-1:0] regs [NREGS];
  logic [NRD-1:0]    busy_pre, busy_post;
  logic [NRD-1:0][WORD_W-1:0] rd_q;
  logic [NRD-1:0]             busy_q;

  rf_scoreboard #(
    .ADDR_W(ADDR_W), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .alloc_en  (alloc_en),
    .alloc_addr(alloc_addr),
    .we        (we),
    .wa        (wa),
    .ra        (ra),
    .busy_pre  (busy_pre),
    .busy_post (busy_post)
  );

  // Ascending port order lets the highest write port win an address conflict.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++)
        if (we[j] && (wa[j*ADDR_W +: ADDR_W] != '0))
          regs[wa[j*ADDR_W +: ADDR_W]] <= wd[j*WORD_W +: WORD_W];
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              fwd_hit;
    logic [WORD_W-1:0] fwd_data, rdata;
    logic              rbusy;

    assign addr = ra[i*ADDR_W +: ADDR_W];

    always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int j = 0; j < NWR; j++)
        if (we[j] && (wa[j*ADDR_W +: ADDR_W] == addr) && (addr != '0)) begin
          fwd_hit  = 1'b1;
          fwd_data = wd[j*WORD_W +: WORD_W];
        end
    end

    // x0 is forced to zero so it reads clean even before the first reset.
    always_comb begin
      rdata = regs[addr];
      if (BYPASS && fwd_hit) rdata = fwd_data;
      if (addr == '0)        rdata = '0;
      rbusy = BYPASS ? busy_post[i] : busy_pre[i];
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_q[i]   <= '0;
        busy_q[i] <= 1'b0;
      end else if (rd_en[i]) begin
        rd_q[i]   <= rdata;
        busy_q[i] <= rbusy;
      end
    end
  end

  assign rd      = rd_q;
  assign rd_busy = busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench: a forwarding and a non-forwarding instance share one stimulus stream.
module tb_reg_file_mp;
  localparam int W = 32, A = 5, NRD = 2, NWR = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [NRD-1:0]   rd_en;
  logic [NRD*A-1:0] ra;
  logic [NWR-1:0]   we;
  logic [NWR*A-1:0] wa;
  logic [NWR*W-1:0] wd;
  logic             alloc_en;
  logic [A-1:0]     alloc_addr;
  logic [NRD*W-1:0] rd_b, rd_n;
  logic [NRD-1:0]   bz_b, bz_n;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.WORD_W(W), .ADDR_W(A), .NRD(NRD), .NWR(NWR), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .ra(ra), .rd(rd_b), .rd_busy(bz_b),
    .we(we), .wa(wa), .wd(wd), .alloc_en(alloc_en), .alloc_addr(alloc_addr));

  reg_file_mp #(.WORD_W(W), .ADDR_W(A), .NRD(NRD), .NWR(NWR), .BYPASS(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .ra(ra), .rd(rd_n), .rd_busy(bz_n),
    .we(we), .wa(wa), .wd(wd), .alloc_en(alloc_en), .alloc_addr(alloc_addr));

  task automatic idle();
    rd_en = '0; ra = '0; we = '0; wa = '0; wd = '0; alloc_en = 1'b0; alloc_addr = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic wr(input int p, input logic [A-1:0] a, input logic [W-1:0] d);
    we[p] = 1'b1; wa[p*A +: A] = a; wd[p*W +: W] = d;
  endtask

  task automatic rdp(input int p, input logic [A-1:0] a);
    rd_en[p] = 1'b1; ra[p*A +: A] = a;
  endtask

  task automatic test_reset();
    idle(); rst_n = 1'b0;
    wr(0, 5'd5, 32'hFFFF_FFFF); alloc_en = 1'b1; alloc_addr = 5'd5;
    step();
    checks++;
    if (rd_b !== '0 || bz_b !== '0) begin
      failures++; $display("FAIL reset_outputs: rd=%h busy=%b want 0/0", rd_b, bz_b);
    end
    rst_n = 1'b1;
    rdp(0, 5'd5); step();
    checks++;
    if (rd_b[W-1:0] !== 32'h0 || bz_b[0] !== 1'b0) begin
      failures++; $display("FAIL reset_read_x5: rd=%h busy=%b want 0/0", rd_b[W-1:0], bz_b[0]);
    end
  endtask

  task automatic test_write_latency();
    wr(0, 5'd3, 32'hDEAD_BEEF); step();
    rdp(0, 5'd3); step();
    checks++;
    if (rd_b[W-1:0] !== 32'hDEAD_BEEF || rd_n[W-1:0] !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL write_read_x3: byp=%h nobyp=%h want deadbeef", rd_b[W-1:0], rd_n[W-1:0]);
    end
    wr(0, 5'd0, 32'h1234); rdp(1, 5'd0); step();
    checks++;
    if (rd_b[2*W-1:W] !== 32'h0 || bz_b[1] !== 1'b0) begin
      failures++; $display("FAIL x0_same_cycle: rd=%h busy=%b want 0/0", rd_b[2*W-1:W], bz_b[1]);
    end
    rdp(0, 5'd0); step();
    checks++;
    if (rd_b[W-1:0] !== 32'h0 || rd_n[W-1:0] !== 32'h0) begin
      failures++; $display("FAIL x0_read: byp=%h nobyp=%h want 0", rd_b[W-1:0], rd_n[W-1:0]);
    end
  endtask

  task automatic test_bypass();
    wr(0, 5'd7, 32'h11); step();
    wr(0, 5'd7, 32'hA5A5_A5A5); rdp(0, 5'd7); step();
    checks++;
    if (rd_b[W-1:0] !== 32'hA5A5_A5A5) begin
      failures++; $display("FAIL bypass_fwd: rd=%h want a5a5a5a5", rd_b[W-1:0]);
    end
    checks++;
    if (rd_n[W-1:0] !== 32'h11) begin
      failures++; $display("FAIL nobypass_old: rd=%h want 11", rd_n[W-1:0]);
    end
    rdp(0, 5'd7); step();
    checks++;
    if (rd_n[W-1:0] !== 32'hA5A5_A5A5) begin
      failures++; $display("FAIL nobypass_later: rd=%h want a5a5a5a5", rd_n[W-1:0]);
    end
  endtask

  task automatic test_dual_write();
    wr(0, 5'd9, 32'h1); wr(1, 5'd9, 32'h2); rdp(1, 5'd9); step();
    checks++;
    if (rd_b[2*W-1:W] !== 32'h2 || rd_n[2*W-1:W] !== 32'h0) begin
      failures++; $display("FAIL dual_same_cycle: byp=%h nobyp=%h want 2/0", rd_b[2*W-1:W], rd_n[2*W-1:W]);
    end
    rdp(0, 5'd9); rdp(1, 5'd9); step();
    checks++;
    if (rd_b[W-1:0] !== 32'h2 || rd_n[2*W-1:W] !== 32'h2) begin
      failures++; $display("FAIL dual_winner: byp=%h nobyp=%h want 2", rd_b[W-1:0], rd_n[2*W-1:W]);
    end
  endtask

  task automatic test_scoreboard();
    alloc_en = 1'b1; alloc_addr = 5'd4; rdp(1, 5'd4); step();
    checks++;
    if (bz_b[1] !== 1'b1 || bz_n[1] !== 1'b0) begin
      failures++; $display("FAIL alloc_same_cycle: byp=%b nobyp=%b want 1/0", bz_b[1], bz_n[1]);
    end
    rdp(0, 5'd4); step();
    checks++;
    if (bz_b[0] !== 1'b1 || bz_n[0] !== 1'b1) begin
      failures++; $display("FAIL alloc_busy: byp=%b nobyp=%b want 1", bz_b[0], bz_n[0]);
    end
    step();
    checks++;
    if (bz_b[0] !== 1'b1 || rd_b[W-1:0] !== 32'h0) begin
      failures++; $display("FAIL hold_no_en: busy=%b rd=%h want 1/0", bz_b[0], rd_b[W-1:0]);
    end
    wr(0, 5'd4, 32'h44); rdp(0, 5'd4); step();
    checks++;
    if (bz_b[0] !== 1'b0 || bz_n[0] !== 1'b1) begin
      failures++; $display("FAIL clear_same_cycle: byp=%b nobyp=%b want 0/1", bz_b[0], bz_n[0]);
    end
    rdp(0, 5'd4); step();
    checks++;
    if (bz_b[0] !== 1'b0 || bz_n[0] !== 1'b0 || rd_n[W-1:0] !== 32'h44) begin
      failures++; $display("FAIL write_clears: byp=%b nobyp=%b rd=%h want 0/0/44", bz_b[0], bz_n[0], rd_n[W-1:0]);
    end
    alloc_en = 1'b1; alloc_addr = 5'd4; wr(1, 5'd4, 32'h45); step();
    rdp(0, 5'd4); step();
    checks++;
    if (bz_b[0] !== 1'b1 || bz_n[0] !== 1'b1) begin
      failures++; $display("FAIL set_beats_clear: byp=%b nobyp=%b want 1", bz_b[0], bz_n[0]);
    end
    alloc_en = 1'b1; alloc_addr = 5'd0; step();
    rdp(1, 5'd0); step();
    checks++;
    if (bz_b[1] !== 1'b0 || bz_n[1] !== 1'b0) begin
      failures++; $display("FAIL alloc_x0: byp=%b nobyp=%b want 0", bz_b[1], bz_n[1]);
    end
  endtask

  task automatic test_reset_mid();
    wr(0, 5'd2, 32'h55); step();
    alloc_en = 1'b1; alloc_addr = 5'd2; step();
    rdp(0, 5'd2); step();
    checks++;
    if (rd_b[W-1:0] !== 32'h55 || bz_b[0] !== 1'b1) begin
      failures++; $display("FAIL pre_reset_x2: rd=%h busy=%b want 55/1", rd_b[W-1:0], bz_b[0]);
    end
    rst_n = 1'b0; wr(0, 5'd2, 32'h66); alloc_en = 1'b1; alloc_addr = 5'd2; rdp(0, 5'd2); step();
    rst_n = 1'b1;
    checks++;
    if (rd_b[W-1:0] !== 32'h0 || bz_b[0] !== 1'b0) begin
      failures++; $display("FAIL reset_beats_write: rd=%h busy=%b want 0/0", rd_b[W-1:0], bz_b[0]);
    end
    rdp(0, 5'd2); rdp(1, 5'd4); step();
    checks++;
    if (rd_b[W-1:0] !== 32'h0 || bz_b !== 2'b00 || rd_n[W-1:0] !== 32'h0 || bz_n !== 2'b00) begin
      failures++; $display("FAIL post_reset_x2: rd=%h/%h busy=%b/%b want 0", rd_b[W-1:0], rd_n[W-1:0], bz_b, bz_n);
    end
  endtask

  initial begin
    idle(); rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_write_latency();
    test_bypass();
    test_dual_write();
    test_scoreboard();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
